hazard_control: RTL and testbench
=================================

Name: hazard_control

Overview:
- Hazard detection and stall/flush control for the 5-stage MIPS pipeline.
- Sits in ID, beside the forwarding unit. It decides when the IF/ID and ID/EX registers hold or bubble, so that every remaining RAW dependence can be resolved by forwarding: ALU path from EX/MEM or MEM/WB; equality comparator in ID.
- Handles load-use stalls, branch-in-ID dependence stalls (1 or 2 cycles, tracked by an FSM), and taken-branch/jump flushes.
- Keeps saturating stall/flush performance counters.

Parameters:
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- IfIdRegRs  in  5  rs field of the instruction in ID.
- IfIdRegRt  in  5  rt field of the instruction in ID.
- IfIdUsesRt  in  1  instruction in ID reads rt (R-type, beq/bne, sw).
- Branch  in  1  instruction in ID is beq/bne.
- BranchTaken  in  1  ID comparator result, after forwarding.
- Jump  in  1  instruction in ID is j/jal.
- IdExMemRead  in  1  instruction in EX is a load.
- IdExRegWrite  in  1  instruction in EX writes a register.
- IdExRegRd  in  5  destination register of the EX instruction (after RegDst mux).
- ExMemMemRead  in  1  instruction in MEM is a load.
- ExMemRegRd  in  5  destination register of the MEM instruction.
- PcWrite  out  1  PC update enable.
- IfIdWrite  out  1  IF/ID register write enable.
- IfIdFlush  out  1  zero IF/ID next edge (squash fetched instruction).
- IdExFlush  out  1  insert bubble into ID/EX (zero control bits).
- Stalling  out  1  a stall is asserted this cycle.
- StallCycles  out  CNT_W  saturating count of stall cycles.
- FlushCount  out  CNT_W  saturating count of IF/ID flushes.

Behaviour:
- Reset is asynchronous and active-high: while rst=1, state=RUN, StallCycles=0, FlushCount=0. PcWrite, IfIdWrite, IfIdFlush, IdExFlush and Stalling follow the RUN decode of the inputs, so they are 1/1/0/0/0 when no hazard or flush condition holds.
- matchEx = IdExRegRd!=0 && (IdExRegRd==IfIdRegRs || (IfIdUsesRt && IdExRegRd==IfIdRegRt)).
- matchMem = same condition using ExMemRegRd.
- Required stall count need[1:0], evaluated combinationally in RUN, maximum of the following:
  - load-use: IdExMemRead && matchEx -> 1.
  - branch on ALU result in EX: Branch && IdExRegWrite && !IdExMemRead && matchEx -> 1.
  - branch on load in EX: Branch && IdExMemRead && matchEx -> 2.
  - branch on load in MEM: Branch && ExMemMemRead && matchMem -> 1.
- FSM with two states, RUN and HOLD:
  - RUN, need=0: no stall.
  - RUN, need>=1: stall this cycle (same-cycle, combinational outputs).
  - RUN, need=2: next state HOLD.
  - RUN, otherwise: stay in RUN.
  - HOLD: stall unconditionally, independent of inputs; next state RUN. HOLD lasts exactly one cycle.
- Stall outputs: PcWrite=0, IfIdWrite=0, IdExFlush=1, Stalling=1. Otherwise PcWrite=1, IfIdWrite=1, IdExFlush=0, Stalling=0.
- IfIdFlush = !Stalling && ((Branch && BranchTaken) || Jump).
  - Stall has priority: a branch is never resolved, and never flushes, while stalling.
  - The flush takes effect at the same edge the PC loads the target.
- Counters update at the rising edge:
  - StallCycles += 1 when Stalling.
  - FlushCount += 1 when IfIdFlush.
  - Both saturate at all-ones and never wrap.
- Register 0 never causes a stall.
- A reset asserted in HOLD returns the FSM to RUN immediately; no residual stall after rst deasserts.
- Jump with a simultaneous stall condition: the stall wins; the flush occurs on the first non-stall cycle.

Decomposition:
- Shared package (pipeline_pkg), already holding the forwarding select encodings:
  - FSM state encoding (RUN=1'b0, HOLD=1'b1).
  - REG_ZERO=5'd0.
  - Stall-count constants NEED_0/NEED_1/NEED_2.
- One sub-module, sat_counter (CNT_W wide, enable, async active-high reset), instantiated twice for StallCycles and FlushCount.
- Hazard decode and FSM stay in the top module.

Test Plan:
- Load-use: EX = lw $t0 (IdExMemRead=1, IdExRegRd=8); ID = add reading rs=8 -> one cycle with PcWrite=0, IfIdWrite=0, IdExFlush=1; StallCycles 0->1; FSM stays in RUN.
- Branch after load: EX = lw $8; ID = beq rs=8 -> two consecutive stall cycles (RUN then HOLD), then RUN with no stall; StallCycles=2; IfIdFlush=0 during both stall cycles.
- Branch after ALU op: IdExRegWrite=1, IdExMemRead=0, IdExRegRd=9; ID = beq rt=9 with IfIdUsesRt=1 -> exactly one stall cycle. Repeat with IdExRegRd=0 -> no stall.
- Taken branch and jump: no hazards; Branch=1, BranchTaken=1 -> IfIdFlush=1, FlushCount=1. Next Jump=1 -> FlushCount=2. Branch=1, BranchTaken=0 -> IfIdFlush=0.
- Reset mid-HOLD: enter HOLD via the lw/beq case, assert rst asynchronously mid-cycle -> counters 0 immediately; FSM returns to RUN; after deassert with no hazards, PcWrite=1 and no stall.
- Saturation: CNT_W=4, hold a load-use condition for 20 cycles -> StallCycles reaches 15 and stays at 15.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline encodings: forwarding selects, hazard FSM states,
// register-zero constant and stall-count values.
package pipeline_pkg;

  typedef enum logic [1:0] {
    FWD_ID  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwdSel_t;

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } hzState_t;

  typedef logic [1:0] need_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam need_t NEED_0 = 2'd0;
  localparam need_t NEED_1 = 2'd1;
  localparam need_t NEED_2 = 2'd2;

endpackage

// File: rtl/hazard_control_if.sv
// Hazard unit bundle: ID/EX/MEM hazard inputs, stall/flush controls
// and performance counters. master = pipeline side, slave = hazard unit.
interface hazard_control_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       IfIdRegRs;
  logic [4:0]       IfIdRegRt;
  logic             IfIdUsesRt;
  logic             Branch;
  logic             BranchTaken;
  logic             Jump;
  logic             IdExMemRead;
  logic             IdExRegWrite;
  logic [4:0]       IdExRegRd;
  logic             ExMemMemRead;
  logic [4:0]       ExMemRegRd;
  logic             PcWrite;
  logic             IfIdWrite;
  logic             IfIdFlush;
  logic             IdExFlush;
  logic             Stalling;
  logic [CNT_W-1:0] StallCycles;
  logic [CNT_W-1:0] FlushCount;

  modport master (
    output IfIdRegRs, IfIdRegRt, IfIdUsesRt,
    output Branch, BranchTaken, Jump,
    output IdExMemRead, IdExRegWrite, IdExRegRd,
    output ExMemMemRead, ExMemRegRd,
    input  PcWrite, IfIdWrite, IfIdFlush,
    input  IdExFlush, Stalling,
    input  StallCycles, FlushCount
  );

  modport slave (
    input  IfIdRegRs, IfIdRegRt, IfIdUsesRt,
    input  Branch, BranchTaken, Jump,
    input  IdExMemRead, IdExRegWrite, IdExRegRd,
    input  ExMemMemRead, ExMemRegRd,
    output PcWrite, IfIdWrite, IfIdFlush,
    output IdExFlush, Stalling,
    output StallCycles, FlushCount
  );
endinterface

// File: rtl/hazard_control_sat_counter.sv
// Saturating up-counter: clk, rst (async high), en, count.
// Sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/hazard_control.sv
// Hazard detection and stall/flush control in ID.
// Ports: clk, rst (async high), hz (hazard_control_if.slave).
module hazard_control
  import pipeline_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input logic             clk,
  input logic             rst,
  hazard_control_if.slave hz
);

  hzState_t state;
  need_t    need;
  logic     matchEx;
  logic     matchMem;
  logic     loadUse;
  logic     brAlu;
  logic     brLoadEx;
  logic     brLoadMem;
  logic     stall;
  logic     flush;

  assign matchEx = (hz.IdExRegRd != REG_ZERO) &&
    ((hz.IdExRegRd == hz.IfIdRegRs) ||
     (hz.IfIdUsesRt && hz.IdExRegRd == hz.IfIdRegRt));

  assign matchMem = (hz.ExMemRegRd != REG_ZERO) &&
    ((hz.ExMemRegRd == hz.IfIdRegRs) ||
     (hz.IfIdUsesRt && hz.ExMemRegRd == hz.IfIdRegRt));

  assign loadUse   = hz.IdExMemRead && matchEx;
  assign brAlu     = hz.Branch && hz.IdExRegWrite &&
                     !hz.IdExMemRead && matchEx;
  assign brLoadEx  = hz.Branch && hz.IdExMemRead && matchEx;
  assign brLoadMem = hz.Branch && hz.ExMemMemRead && matchMem;

  always_comb begin
    need = NEED_0;
    if (loadUse || brAlu || brLoadMem) need = NEED_1;
    if (brLoadEx) need = NEED_2;
  end

  // HOLD stalls regardless of what is now in EX/MEM.
  assign stall = (state == HOLD) || (need != NEED_0);
  // A stalled branch is not resolved yet, so it must not flush.
  assign flush = !stall &&
                 ((hz.Branch && hz.BranchTaken) || hz.Jump);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
    end else begin
      unique case (state)
        RUN:  state <= (need == NEED_2) ? HOLD : RUN;
        HOLD: state <= RUN;
      endcase
    end
  end

  assign hz.PcWrite   = !stall;
  assign hz.IfIdWrite = !stall;
  assign hz.IdExFlush = stall;
  assign hz.Stalling  = stall;
  assign hz.IfIdFlush = flush;

  sat_counter #(.W(CNT_W)) uStallCnt (
    .clk   (clk),
    .rst   (rst),
    .en    (stall),
    .count (hz.StallCycles)
  );

  sat_counter #(.W(CNT_W)) uFlushCnt (
    .clk   (clk),
    .rst   (rst),
    .en    (flush),
    .count (hz.FlushCount)
  );

endmodule

// File: tb/tb_hazard_control.sv
// Self-checking bench for hazard_control: vector table, directed
// multi-cycle sequences and a randomized run against a cycle model.
module tb_hazard_control;

  localparam logic [4:0] OUT_RUN   = 5'b11000;
  localparam logic [4:0] OUT_STALL = 5'b00011;
  localparam logic [4:0] OUT_FLUSH = 5'b11100;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  hazard_control_if #(.CNT_W(16)) hif ();
  hazard_control_if #(.CNT_W(4))  hif4 ();

  hazard_control #(.CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hif.slave)
  );

  hazard_control #(.CNT_W(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .hz  (hif4.slave)
  );

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    string      name;
    logic [4:0] rs, rt;
    logic       usesRt, br, taken, jmp;
    logic       exMr, exRw;
    logic [4:0] exRd;
    logic       memMr;
    logic [4:0] memRd;
    logic [4:0] expOut;
    logic       expHold;
  } vec_t;

  vec_t vecs[15];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [4:0] outs();
    return {hif.PcWrite, hif.IfIdWrite, hif.IfIdFlush,
            hif.IdExFlush, hif.Stalling};
  endfunction

  task automatic setIn(logic [4:0] rs, logic [4:0] rt, logic usesRt,
                       logic br, logic taken, logic jmp,
                       logic exMr, logic exRw, logic [4:0] exRd,
                       logic memMr, logic [4:0] memRd);
    hif.IfIdRegRs    = rs;
    hif.IfIdRegRt    = rt;
    hif.IfIdUsesRt   = usesRt;
    hif.Branch       = br;
    hif.BranchTaken  = taken;
    hif.Jump         = jmp;
    hif.IdExMemRead  = exMr;
    hif.IdExRegWrite = exRw;
    hif.IdExRegRd    = exRd;
    hif.ExMemMemRead = memMr;
    hif.ExMemRegRd   = memRd;
  endtask

  task automatic clearIn();
    setIn(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic pulseReset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    rst = 1'b0;
  endtask

  // Stall cycles demanded by the instruction in ID, from the hazard rules.
  function automatic int needOf();
    bit mEx, mMem;
    int n;
    mEx = hif.IdExRegRd != 0 &&
          (hif.IdExRegRd == hif.IfIdRegRs ||
           (hif.IfIdUsesRt && hif.IdExRegRd == hif.IfIdRegRt));
    mMem = hif.ExMemRegRd != 0 &&
           (hif.ExMemRegRd == hif.IfIdRegRs ||
            (hif.IfIdUsesRt && hif.ExMemRegRd == hif.IfIdRegRt));
    n = 0;
    if (hif.IdExMemRead && mEx) n = 1;
    if (hif.Branch && hif.IdExRegWrite && !hif.IdExMemRead && mEx) n = 1;
    if (hif.Branch && hif.ExMemMemRead && mMem) n = 1;
    if (hif.Branch && hif.IdExMemRead && mEx) n = 2;
    return n;
  endfunction

  initial begin
    int remain, sCnt, fCnt, n;
    bit stl, fl;

    clearIn();
    hif4.IfIdRegRs = 0; hif4.IfIdRegRt = 0; hif4.IfIdUsesRt = 0;
    hif4.Branch = 0; hif4.BranchTaken = 0; hif4.Jump = 0;
    hif4.IdExMemRead = 0; hif4.IdExRegWrite = 0; hif4.IdExRegRd = 0;
    hif4.ExMemMemRead = 0; hif4.ExMemRegRd = 0;

    // name rs rt uRt br tk j exMr exRw exRd memMr memRd out hold
    vecs[0]  = '{"lduse_rs", 8, 0, 0, 0, 0, 0, 1, 1, 8, 0, 0, OUT_STALL, 0};
    vecs[1]  = '{"lduse_rt_unused", 1, 8, 0, 0, 0, 0, 1, 1, 8, 0, 0, OUT_RUN, 0};
    vecs[2]  = '{"lduse_rt", 1, 8, 1, 0, 0, 0, 1, 1, 8, 0, 0, OUT_STALL, 0};
    vecs[3]  = '{"lduse_r0", 0, 0, 1, 0, 0, 0, 1, 1, 0, 0, 0, OUT_RUN, 0};
    vecs[4]  = '{"br_alu", 3, 9, 1, 1, 0, 0, 0, 1, 9, 0, 0, OUT_STALL, 0};
    vecs[5]  = '{"br_alu_r0", 0, 0, 1, 1, 0, 0, 0, 1, 0, 0, 0, OUT_RUN, 0};
    vecs[6]  = '{"br_load_ex", 8, 2, 1, 1, 0, 0, 1, 1, 8, 0, 0, OUT_STALL, 1};
    vecs[7]  = '{"br_load_mem", 10, 2, 1, 1, 0, 0, 0, 0, 0, 1, 10, OUT_STALL, 0};
    vecs[8]  = '{"alu_load_mem", 10, 2, 1, 0, 0, 0, 0, 0, 0, 1, 10, OUT_RUN, 0};
    vecs[9]  = '{"br_taken", 4, 5, 1, 1, 1, 0, 0, 1, 7, 0, 0, OUT_FLUSH, 0};
    vecs[10] = '{"jump", 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, OUT_FLUSH, 0};
    vecs[11] = '{"br_not_taken", 4, 5, 1, 1, 0, 0, 0, 0, 0, 0, 0, OUT_RUN, 0};
    vecs[12] = '{"br_taken_stall", 6, 5, 1, 1, 1, 0, 0, 1, 6, 0, 0, OUT_STALL, 0};
    vecs[13] = '{"jump_stall", 8, 0, 0, 0, 0, 1, 1, 1, 8, 0, 0, OUT_STALL, 0};
    vecs[14] = '{"alu_ex_fwd", 8, 9, 1, 0, 0, 0, 0, 1, 9, 0, 0, OUT_RUN, 0};

    pulseReset();
    #1;
    check("reset_outs", 32'(outs()), 32'(OUT_RUN));
    check("reset_stallcnt", 32'(hif.StallCycles), 0);
    check("reset_flushcnt", 32'(hif.FlushCount), 0);

    foreach (vecs[i]) begin
      pulseReset();
      setIn(vecs[i].rs, vecs[i].rt, vecs[i].usesRt, vecs[i].br,
            vecs[i].taken, vecs[i].jmp, vecs[i].exMr, vecs[i].exRw,
            vecs[i].exRd, vecs[i].memMr, vecs[i].memRd);
      #1;
      check(vecs[i].name, 32'(outs()), 32'(vecs[i].expOut));
      @(posedge clk);
      #1;
      clearIn();
      #1;
      check({vecs[i].name, "_next"}, 32'(outs()),
            32'(vecs[i].expHold ? OUT_STALL : OUT_RUN));
    end

    // load-use: one stall, counter 0->1, then back to normal flow
    pulseReset();
    setIn(8, 0, 0, 0, 0, 0, 1, 1, 8, 0, 0);
    #1;
    check("lu_stall", 32'(outs()), 32'(OUT_STALL));
    check("lu_cnt0", 32'(hif.StallCycles), 0);
    @(posedge clk);
    #1;
    check("lu_cnt1", 32'(hif.StallCycles), 1);
    clearIn();
    #1;
    check("lu_run", 32'(outs()), 32'(OUT_RUN));

    // beq after lw: RUN stall, HOLD stall, then resolve and flush
    pulseReset();
    setIn(8, 0, 1, 1, 1, 0, 1, 1, 8, 0, 0);
    #1;
    check("bl_stall1", 32'(outs()), 32'(OUT_STALL));
    @(negedge clk);
    setIn(8, 0, 1, 1, 1, 0, 0, 0, 0, 1, 8);
    #1;
    check("bl_stall2", 32'(outs()), 32'(OUT_STALL));
    @(negedge clk);
    setIn(8, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0);
    #1;
    check("bl_resolve", 32'(outs()), 32'(OUT_FLUSH));
    check("bl_stallcnt", 32'(hif.StallCycles), 2);
    check("bl_flushcnt0", 32'(hif.FlushCount), 0);
    @(posedge clk);
    #1;
    check("bl_flushcnt1", 32'(hif.FlushCount), 1);

    // taken branch, jump, not-taken branch
    pulseReset();
    setIn(4, 5, 1, 1, 1, 0, 0, 0, 0, 0, 0);
    #1;
    check("tj_br", 32'(outs()), 32'(OUT_FLUSH));
    @(negedge clk);
    setIn(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    #1;
    check("tj_cnt1", 32'(hif.FlushCount), 1);
    check("tj_jump", 32'(outs()), 32'(OUT_FLUSH));
    @(negedge clk);
    setIn(4, 5, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check("tj_cnt2", 32'(hif.FlushCount), 2);
    check("tj_nt", 32'(outs()), 32'(OUT_RUN));

    // jump during load-use: stall first, flush afterwards
    pulseReset();
    setIn(8, 0, 0, 0, 0, 1, 1, 1, 8, 0, 0);
    #1;
    check("js_stall", 32'(outs()), 32'(OUT_STALL));
    @(negedge clk);
    setIn(8, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    #1;
    check("js_flush", 32'(outs()), 32'(OUT_FLUSH));
    check("js_flushcnt", 32'(hif.FlushCount), 0);

    // async reset while in HOLD
    pulseReset();
    setIn(8, 0, 1, 1, 1, 0, 1, 1, 8, 0, 0);
    @(posedge clk);
    #1;
    clearIn();
    #1;
    check("rh_hold", 32'(outs()), 32'(OUT_STALL));
    check("rh_cnt_pre", 32'(hif.StallCycles), 1);
    rst = 1'b1;
    #1;
    check("rh_cnt_rst", 32'(hif.StallCycles), 0);
    check("rh_outs_rst", 32'(outs()), 32'(OUT_RUN));
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rh_after", 32'(outs()), 32'(OUT_RUN));
    check("rh_cnt_after", 32'(hif.StallCycles), 0);

    // 4-bit counter saturation
    pulseReset();
    hif4.IfIdRegRs = 8;
    hif4.IdExMemRead = 1;
    hif4.IdExRegWrite = 1;
    hif4.IdExRegRd = 8;
    repeat (14) @(posedge clk);
    #1;
    check("sat_14", 32'(hif4.StallCycles), 14);
    @(posedge clk);
    #1;
    check("sat_15", 32'(hif4.StallCycles), 15);
    repeat (5) @(posedge clk);
    #1;
    check("sat_hold", 32'(hif4.StallCycles), 15);
    hif4.IdExMemRead = 0;
    hif4.IdExRegWrite = 0;
    hif4.IdExRegRd = 0;

    // randomized run against a cycle-level model
    pulseReset();
    remain = 0;
    sCnt = 0;
    fCnt = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      setIn(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 3)));
      #1;
      n = needOf();
      stl = (remain > 0) || (n > 0);
      fl = !stl && ((hif.Branch && hif.BranchTaken) || hif.Jump);
      check($sformatf("rnd%0d_outs", c), 32'(outs()),
            32'({!stl, !stl, fl, stl, stl}));
      check($sformatf("rnd%0d_scnt", c), 32'(hif.StallCycles), sCnt);
      check($sformatf("rnd%0d_fcnt", c), 32'(hif.FlushCount), fCnt);
      if (remain > 0) remain--;
      else if (n > 0) remain = n - 1;
      if (stl && sCnt < 65535) sCnt++;
      if (fl && fCnt < 65535) fCnt++;
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
